// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one RAM port between an instruction-cache reader and a data-cache
//   reader/writer. A grant is chosen in IDLE and registered; the granted side
//   is then served until the RAM reports ACCESS or ERROR, or until a watchdog
//   forces completion. Every access is followed by a one-cycle GAP before the
//   next grant.
//
// Handshake: a requester raises its request (iREN, or dREN/dWEN) and holds it,
//   together with its address and store data, until it sees its wait line low
//   for one cycle. That cycle is the completion; the load data is valid only
//   then. Dropping a request before completion abandons the access silently.
//
// Configuration:
//   MEM_ARBITER_FAIR_EN  defined   -> alternate grants when both sides wait
//                        undefined -> data side always wins
//
// Parameters:
//   TIMEOUT  service cycles (1..255) before completion is forced
//   BADWORD  load value returned on an error or forced completion
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          instruction read request / address
//   iwait, iload         instruction wait (low on completion) / read data
//   dREN, dWEN           data read / write request (both high = write)
//   daddr, dstore        data address / write value
//   dwait, dload         data wait (low on completion) / read data
//   ramREN, ramWEN       RAM strobes
//   ramaddr, ramstore    RAM address / write data (0 when no strobe)
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   err                  sticky error-or-timeout flag, cleared by reset only
//   dbg_state            current FSM state (IDLE=0, ISERV=1, DSERV=2, GAP=3)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  // The counter holds the number of service cycles already spent without
  // completion, so the forcing cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        d_req;
  logic        prefer_i;
  logic        acc_hit;
  logic        fail_hit;
  logic [31:0] done_load;

  assign d_req     = dREN | dWEN;
  assign acc_hit   = (ramstate == RS_ACCESS);
  // ERROR or watchdog expiry; only meaningful when acc_hit is low.
  assign fail_hit  = (ramstate == RS_ERROR) || (cnt_q == CNT_LAST);
  assign done_load = acc_hit ? ramload : BADWORD;

`ifdef MEM_ARBITER_FAIR_EN
  logic last_d_q, last_d_d;
  assign prefer_i = last_d_q;
`else
  assign prefer_i = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
`ifdef MEM_ARBITER_FAIR_EN
    last_d_d = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Data wins unless fairness hands this contested slot to i.
        if (d_req && !(iREN && prefer_i)) begin
          state_d = DSERV;
        end else if (iREN) begin
          state_d = ISERV;
        end
      end

      ISERV: begin
        if (!iREN) begin
          state_d = GAP;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (acc_hit || fail_hit) begin
            iwait   = 1'b0;
            iload   = done_load;
            state_d = GAP;
            if (!acc_hit) err_d = 1'b1;
`ifdef MEM_ARBITER_FAIR_EN
            last_d_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      DSERV: begin
        if (!d_req) begin
          state_d = GAP;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (acc_hit || fail_hit) begin
            dwait   = 1'b0;
            dload   = done_load;
            state_d = GAP;
            if (!acc_hit) err_d = 1'b1;
`ifdef MEM_ARBITER_FAIR_EN
            last_d_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_ARBITER_FAIR_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios for the documented sequences plus a randomized run
//   against a transaction-level reference model. Inputs change on the falling
//   edge; outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned TO     = 4;
  localparam logic [31:0] BAD    = 32'hBAD1BAD1;
  localparam logic [1:0]  RS_FREE   = 2'd0;
  localparam logic [1:0]  RS_BUSY   = 2'd1;
  localparam logic [1:0]  RS_ACCESS = 2'd2;
  localparam logic [1:0]  RS_ERROR  = 2'd3;
  localparam logic [7:0]  CH_D = 8'h44;
  localparam logic [7:0]  CH_I = 8'h49;
`ifdef MEM_ARBITER_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TO), .BADWORD(BAD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = RS_FREE;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h1234; daddr = 32'h5678; dstore = 32'h9ABC;
    ramstate = RS_ACCESS; ramload = 32'hFFFF_FFFF;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload, err}
        !== {2'b00, 64'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got ren=%b wen=%b addr=%h store=%h iw=%b il=%h dw=%b dl=%h err=%b expected idle outputs",
               ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload, err);
    end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload}
        !== {2'b00, 64'h0, 1'b1, 32'h0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_release: got ren=%b wen=%b addr=%h iw=%b dw=%b expected no strobe, waits high",
               ramREN, ramWEN, ramaddr, iwait, dwait);
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic test_iread();
    int ren_cycles = 0;
    int done_cycles = 0;
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY; ramload = 32'h8C010004;
    #1;
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL iread_idle: got ren=%b iwait=%b expected 0/1", ramREN, iwait);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (c == 2) ramstate = RS_ACCESS;
      #1;
      if (ramREN === 1'b1) ren_cycles++;
      if (iwait === 1'b0) done_cycles++;
      checks++;
      if (ramaddr !== 32'h40 || ramWEN !== 1'b0 || dwait !== 1'b1 || iwait !== (c != 2)) begin
        errors++;
        $display("FAIL iread_serv%0d: got addr=%h wen=%b dwait=%b iwait=%b expected 40/0/1/%b",
                 c, ramaddr, ramWEN, dwait, iwait, (c != 2));
      end
      if (c == 2) begin
        checks++;
        if (iload !== 32'h8C010004) begin
          errors++;
          $display("FAIL iread_load: got %h expected 8c010004", iload);
        end
      end
    end
    @(negedge CLK);
    iREN = 1'b0; ramstate = RS_FREE;
    #1;
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1 || iload !== 32'h0 || ramaddr !== 32'h0) begin
      errors++;
      $display("FAIL iread_gap: got ren=%b iwait=%b iload=%h addr=%h expected 0/1/0/0",
               ramREN, iwait, iload, ramaddr);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (ren_cycles != 3 || done_cycles != 1 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL iread_count: got ren_cycles=%0d done=%0d ren_now=%b expected 3/1/0",
               ren_cycles, done_cycles, ramREN);
    end
  endtask

  task automatic test_dwrite();
    do_reset();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hCAFE; ramstate = RS_ACCESS;
    ramload = 32'h7777_0000;
    #1;
    checks++;
    if (ramWEN !== 1'b0 || ramstore !== 32'h0 || dwait !== 1'b1) begin
      errors++;
      $display("FAIL dwrite_idle: got wen=%b store=%h dwait=%b expected 0/0/1", ramWEN, ramstore, dwait);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait}
        !== {2'b10, 32'h100, 32'hCAFE, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dwrite_serv: got wen=%b ren=%b addr=%h store=%h dwait=%b iwait=%b expected 1/0/100/cafe/0/1",
               ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
    end
    @(negedge CLK);
    dWEN = 1'b0;
    #1;
    checks++;
    if (ramWEN !== 1'b0 || ramstore !== 32'h0 || dwait !== 1'b1 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL dwrite_gap: got wen=%b store=%h dwait=%b iwait=%b expected 0/0/1/1",
               ramWEN, ramstore, dwait, iwait);
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_q[$];
    logic [7:0] who;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back((FAIR && (k % 2 == 1)) ? CH_I : CH_D);
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h44; daddr = 32'h88; ramstate = RS_ACCESS;
    for (int c = 0; c < 12; c++) begin
      ramload = $urandom;
      #1;
      if (iwait === 1'b0 || dwait === 1'b0) begin
        who = (dwait === 1'b0) ? CH_D : CH_I;
        checks++;
        if (iwait === 1'b0 && dwait === 1'b0) begin
          errors++;
          $display("FAIL prio_both: cycle %0d both waits low, expected one", c);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL prio_extra: cycle %0d got grant %c expected none", c, who);
        end else begin
          want = exp_q.pop_front();
          if (who !== want) begin
            errors++;
            $display("FAIL prio_order: cycle %0d got %c expected %c", c, who, want);
          end
        end
        checks++;
        if (((who == CH_D) ? dload : iload) !== ramload) begin
          errors++;
          $display("FAIL prio_load: cycle %0d got %h expected %h", c,
                   (who == CH_D) ? dload : iload, ramload);
        end
      end
      @(negedge CLK);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL prio_missing: got %0d completions expected 4", 4 - exp_q.size());
    end
    iREN = 1'b0; dREN = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    iREN = 1'b1; iaddr = 32'h200; ramstate = RS_BUSY; ramload = 32'h1111_2222;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (iwait !== (c != 4) || err !== 1'b0 || ramREN !== 1'b1) begin
        errors++;
        $display("FAIL timeout_cyc%0d: got iwait=%b err=%b ren=%b expected %b/0/1",
                 c, iwait, err, ramREN, (c != 4));
      end
    end
    checks++;
    if (iload !== BAD) begin
      errors++;
      $display("FAIL timeout_load: got %h expected %h", iload, BAD);
    end
    @(negedge CLK);
    iREN = 1'b0; ramstate = RS_FREE;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: got %b expected 1", err);
    end
    repeat (5) @(negedge CLK);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_hold: got %b expected 1", err);
    end
  endtask

  task automatic test_error_reset();
    int late = 0;
    do_reset();
    dREN = 1'b1; daddr = 32'h300; ramstate = RS_ERROR; ramload = 32'h5555_5555;
    @(negedge CLK);
    #1;
    checks++;
    if (dwait !== 1'b0 || dload !== BAD || ramREN !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL error_done: got dwait=%b dload=%h ren=%b err=%b expected 0/%h/1/0",
               dwait, dload, ramREN, err, BAD);
    end
    @(negedge CLK);
    dREN = 1'b0; ramstate = RS_FREE;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL error_flag: got %b expected 1", err);
    end
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h304; ramstate = RS_BUSY;
    @(negedge CLK);
    #1;
    checks++;
    if (ramREN !== 1'b1 || err !== 1'b1 || ramaddr !== 32'h304) begin
      errors++;
      $display("FAIL error_second: got ren=%b err=%b addr=%h expected 1/1/304", ramREN, err, ramaddr);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0 || err !== 1'b0 || dwait !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got ren=%b addr=%h err=%b dwait=%b expected 0/0/0/1",
               ramREN, ramaddr, err, dwait);
    end
    @(negedge CLK);
    dREN = 1'b0; ramstate = RS_ACCESS;
    nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (dwait === 1'b0 || ramREN === 1'b1) late++;
      @(negedge CLK);
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL reset_no_completion: got %0d active cycles expected 0", late);
    end
  endtask

  // Randomized traffic against a transaction model: the model tracks who owns
  // the RAM, how many service cycles the current access has used (1-based),
  // and whether the mandatory turnaround cycle is pending.
  task automatic test_random();
    int owner = 0;        // 0 none, 1 instruction, 2 data
    bit turnaround = 0;
    int age = 0;
    bit m_err = 0;
    bit m_last_d = 0;
    bit i_active = 0;
    bit d_active = 0;
    bit d_rd = 0, d_wr = 0;
    int n_owner, n_age, pick;
    bit n_turn, held, finished;
    logic [132:0] act, expv;
    logic         e_ren, e_wen, e_iw, e_dw;
    logic [31:0]  e_addr, e_store, e_il, e_dl, value;

    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!i_active && $urandom_range(0, 2) == 0) begin
        i_active = 1; iaddr = $urandom;
      end else if (i_active && $urandom_range(0, 24) == 0) begin
        i_active = 0;
      end
      if (!d_active && $urandom_range(0, 2) == 0) begin
        d_active = 1; daddr = $urandom;
        pick = $urandom_range(1, 3);
        d_rd = pick[0]; d_wr = pick[1];
      end else if (d_active && $urandom_range(0, 24) == 0) begin
        d_active = 0;
      end
      iREN = i_active;
      dREN = d_active & d_rd;
      dWEN = d_active & d_wr;
      dstore = $urandom;
      ramload = $urandom;
      pick = $urandom_range(0, 9);
      ramstate = (pick == 0) ? RS_FREE : (pick < 5) ? RS_BUSY : (pick < 9) ? RS_ACCESS : RS_ERROR;
      #1;

      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
      e_iw = 1; e_il = '0; e_dw = 1; e_dl = '0;
      n_owner = owner; n_turn = 0; n_age = age;
      if (turnaround) begin
        n_owner = 0;
      end else if (owner == 0) begin
        if ((dREN | dWEN) && !(iREN && FAIR && m_last_d)) n_owner = 2;
        else if (iREN) n_owner = 1;
        n_age = 1;
      end else begin
        held = (owner == 1) ? iREN : (dREN | dWEN);
        if (!held) begin
          n_owner = 0; n_turn = 1;
        end else begin
          if (owner == 1) begin
            e_ren = 1; e_addr = iaddr;
          end else begin
            e_addr = daddr;
            if (dWEN) begin e_wen = 1; e_store = dstore; end
            else e_ren = 1;
          end
          finished = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR) || (age == TO);
          if (finished) begin
            value = (ramstate == RS_ACCESS) ? ramload : BAD;
            if (owner == 1) begin e_iw = 0; e_il = value; end
            else begin e_dw = 0; e_dl = value; end
            n_owner = 0; n_turn = 1;
            m_last_d = (owner == 2);
          end else begin
            n_age = age + 1;
          end
        end
      end

      act  = {ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload, err};
      expv = {e_ren, e_wen, e_addr, e_store, e_iw, e_il, e_dw, e_dl, m_err};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h expected %h", cyc, act, expv);
      end

      if (finished && held && !turnaround && owner != 0 && ramstate != RS_ACCESS) m_err = 1;
      if (e_iw == 0) i_active = 0;
      if (e_dw == 0) d_active = 0;
      owner = n_owner; turnaround = n_turn; age = n_age;
      finished = 0; held = 0;
      @(negedge CLK);
    end
    iREN = 0; dREN = 0; dWEN = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_iread();
    test_dwrite();
    test_priority();
    test_timeout();
    test_error_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
